module_pmod_spi_ctrl: RTL and testbench
=======================================

// Module: module_pmod_spi_ctrl
// PURPOSE
//  - Bus-side responder and SPI master for the Pmod peripheral.
//  - The CPU writes and reads two registers through addr_i: CTRL at 2'b01 and DATA at every other address.
//  - On a start command the block shifts DATA out on MOSI, MSB first, SPI mode 0, and captures MISO into RX.
//  - Status and RX data are returned to the CPU through a registered read port.
// PARAMETERS
//  CLK_DIV  4  clk_i cycles per SCLK half-period (legal range >= 1)
//  DATA_W   8  bits per SPI transfer (legal range 1..32)
// PORTS
//  clk_i      in   1   system clock; all logic is on the rising edge
//  rst_i      in   1   synchronous, active-high reset
//  we_i       in   1   write strobe, one cycle per write
//  addr_i     in   2   register address: 2'b01 = CTRL, all other values = DATA
//  wr_data_i  in   32  write data
//  rd_data_o  out  32  read data for the addr_i sampled on the previous edge
//  sclk_o     out  1   SPI clock, idles low
//  mosi_o     out  1   SPI data out
//  miso_i     in   1   SPI data in; synchronised internally with 2 flops
//  cs_o       out  1   SPI chip select, active low, idles high
// BEHAVIOUR
//  Reset:
//   - sclk_o=0, mosi_o=0, cs_o=1, rd_data_o=0.
//   - TX, RX, busy, done and the bit counter all clear to 0.
//   - FSM goes to IDLE. A reset mid-transfer aborts it on the next edge; no partial RX is kept.
//  Register map:
//   - CTRL write: bit0=1 starts a transfer. Every CTRL write clears done.
//   - CTRL read:  {30'b0, done, busy}.
//   - DATA write: TX <= wr_data_i[DATA_W-1:0].
//   - DATA read:  {zero-extended RX}.
//  Busy rules:
//   - While busy=1, DATA writes are ignored (TX unchanged).
//   - While busy=1, CTRL start writes are ignored, but they still clear done.
//  Read timing:
//   - rd_data_o updates every cycle with one-cycle latency, independent of we_i.
//   - When a read and a status change fall on the same edge, the read shows the pre-edge value.
//  FSM, IDLE -> SETUP -> SHIFT -> HOLD -> IDLE:
//   - IDLE: busy=0, cs_o=1, sclk_o=0. A start write moves to SETUP on the same edge: busy<=1, shreg<=TX, cs_o<=0.
//   - SETUP: cs_o=0 and mosi_o=shreg[MSB] for CLK_DIV cycles, then go to SHIFT.
//   - SHIFT, per bit:
//     - sclk_o high for CLK_DIV cycles; MISO is sampled on the rising transition.
//     - sclk_o low for CLK_DIV cycles; shreg shifts left on the falling transition, sampled bit enters at LSB.
//     - After DATA_W bits go to HOLD with sclk_o=0.
//   - HOLD: cs_o=0 for CLK_DIV cycles, then:
//     - cs_o<=1, RX<=shreg, busy<=0, done<=1.
//     - Go to IDLE.
//  Timing rules:
//   - Transfer length, CS low to CS high = CLK_DIV*(2*DATA_W+2) cycles (72 at the defaults).
//   - A new start is accepted on the first IDLE cycle, so a minimum of 1 cycle of cs_o high separates transfers.
//   - Divider counter width = $clog2(CLK_DIV+1). The bit counter wraps only through IDLE.
//   - MISO synchroniser latency: the sample taken is the miso_i value 2 clk_i cycles before the rising transition.
// TESTING
//  - Reset: rst_i=1 for 3 cycles -> cs_o=1, sclk_o=0, mosi_o=0; CTRL read = 0; DATA read = 0.
//  - Loopback (mosi_o tied to miso_i): write DATA=0xA5, then CTRL=1.
//    -> Exactly 8 SCLK rising edges; MOSI bits 1,0,1,0,0,1,0,1.
//    -> cs_o low for 72 cycles; then CTRL read = 2'b10 and DATA read = 0xA5.
//  - MISO stuck at 1: TX=0x3C, start -> RX=0xFF, done=1. Then a CTRL write with 0 -> CTRL read = 2'b00.
//  - Busy protection: start with TX=0x12; mid-transfer write DATA=0x77 and CTRL=1.
//    -> Only one transfer happens; MOSI carries 0x12; RX unchanged by the ignored writes; busy stays 1 until HOLD ends.
//  - Address decode: writes to addr 2'b00, 2'b10 and 2'b11 all load TX, reads return RX; only 2'b01 returns status.
//  - Reset at cycle 30 of a transfer -> next edge: cs_o=1, sclk_o=0, busy=0, done=0, RX=0; a new start then runs a full 72-cycle transfer.

Source files
------------

// File: rtl/module_pmod_spi_ctrl.sv
// Pmod SPI master with a two-register CPU port (CTRL / DATA).
// Mode 0, MSB first, registered read port with one-cycle latency.
module module_pmod_spi_ctrl #(
   parameter int CLK_DIV = 4,
   parameter int DATA_W  = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        we_i,
   input  logic [1:0]  addr_i,
   input  logic [31:0] wr_data_i,
   output logic [31:0] rd_data_o,
   output logic        sclk_o,
   output logic        mosi_o,
   input  logic        miso_i,
   output logic        cs_o
);

   localparam int DIV_W = $clog2(CLK_DIV + 1);
   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_HIGH,
      S_LOW,
      S_HOLD
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [DIV_W-1:0]  r_div;
   logic [CNT_W-1:0]  r_bitcnt;
   logic [DATA_W-1:0] r_tx;
   logic [DATA_W-1:0] r_rx;
   logic [DATA_W-1:0] r_shreg;
   logic              r_sample;
   logic              r_busy;
   logic              r_done;
   logic              r_miso_s1;
   logic              r_miso_s2;
   logic [31:0]       r_rd_data;

   logic              w_ctrl_sel;
   logic              w_ctrl_wr;
   logic              w_data_wr;
   logic              w_start;
   logic              w_div_last;
   logic              w_last_bit;
   logic [DATA_W-1:0] w_shift_nxt;

   logic              w_sclk;
   logic              w_cs;
   logic              w_mosi;
   logic              w_rise;
   logic              w_fall;
   logic              w_finish;
   logic              w_unused_bits;

   assign w_ctrl_sel  = (addr_i == 2'b01);
   assign w_ctrl_wr   = we_i & w_ctrl_sel;
   assign w_data_wr   = we_i & ~w_ctrl_sel;
   assign w_start     = w_ctrl_wr & wr_data_i[0]
                      & (r_state == S_IDLE);
   assign w_div_last  = (r_div == DIV_LAST);
   assign w_last_bit  = (r_bitcnt == BIT_LAST);
   assign w_shift_nxt = DATA_W'({r_shreg, r_sample});
   assign w_unused_bits = ^wr_data_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_start) w_state_nxt = S_SETUP;
         end
         S_SETUP: begin
            if (w_div_last) w_state_nxt = S_HIGH;
         end
         S_HIGH: begin
            if (w_div_last) w_state_nxt = S_LOW;
         end
         S_LOW: begin
            if (w_div_last) begin
               if (w_last_bit) w_state_nxt = S_HOLD;
               else            w_state_nxt = S_HIGH;
            end
         end
         S_HOLD: begin
            if (w_div_last) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Strobes mark the last cycle of a phase, i.e. the SCLK edges.
   always_comb begin
      w_sclk   = 1'b0;
      w_cs     = 1'b1;
      w_mosi   = 1'b0;
      w_rise   = 1'b0;
      w_fall   = 1'b0;
      w_finish = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_cs = 1'b1;
         end
         S_SETUP: begin
            w_cs   = 1'b0;
            w_mosi = r_shreg[DATA_W-1];
            w_rise = w_div_last;
         end
         S_HIGH: begin
            w_cs   = 1'b0;
            w_sclk = 1'b1;
            w_mosi = r_shreg[DATA_W-1];
            w_fall = w_div_last;
         end
         S_LOW: begin
            w_cs   = 1'b0;
            w_mosi = r_shreg[DATA_W-1];
            w_rise = w_div_last & ~w_last_bit;
         end
         S_HOLD: begin
            w_cs     = 1'b0;
            w_mosi   = r_shreg[DATA_W-1];
            w_finish = w_div_last;
         end
         default: w_cs = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_div     <= '0;
         r_bitcnt  <= '0;
         r_tx      <= '0;
         r_rx      <= '0;
         r_shreg   <= '0;
         r_sample  <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_miso_s1 <= 1'b0;
         r_miso_s2 <= 1'b0;
         r_rd_data <= '0;
      end else begin
         r_miso_s1 <= miso_i;
         r_miso_s2 <= r_miso_s1;

         if ((r_state == S_IDLE) || w_div_last) begin
            r_div <= '0;
         end else begin
            r_div <= r_div + DIV_W'(1);
         end

         if (w_data_wr && !r_busy) begin
            r_tx <= wr_data_i[DATA_W-1:0];
         end

         if (w_ctrl_wr) begin
            r_done <= 1'b0;
         end

         if (w_start) begin
            r_busy   <= 1'b1;
            r_shreg  <= r_tx;
            r_bitcnt <= '0;
         end

         if (w_rise) begin
            r_sample <= r_miso_s2;
         end

         if (w_fall) begin
            r_shreg  <= w_shift_nxt;
            r_bitcnt <= r_bitcnt + CNT_W'(1);
         end

         // Completion wins over a same-edge CTRL write clearing done.
         if (w_finish) begin
            r_rx   <= r_shreg;
            r_busy <= 1'b0;
            r_done <= 1'b1;
         end

         if (w_ctrl_sel) begin
            r_rd_data <= {30'b0, r_done, r_busy};
         end else begin
            r_rd_data <= 32'(r_rx);
         end
      end
   end

   assign rd_data_o = r_rd_data;
   assign sclk_o    = w_sclk;
   assign mosi_o    = w_mosi;
   assign cs_o      = w_cs;

endmodule

// File: tb/tb_module_pmod_spi_ctrl.sv
// Directed scoreboard bench for module_pmod_spi_ctrl.
// Expected values are queued at stimulus time and popped at each check.
module tb_module_pmod_spi_ctrl;

   logic        clk;
   logic        rst;
   logic        we;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rd_data;
   logic        sclk;
   logic        mosi;
   logic        miso;
   logic        cs;
   logic        loop_en;
   logic        miso_val;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] sb[$];

   int          cs_low_cnt = 0;
   int          rise_cnt   = 0;
   logic [31:0] mosi_hist  = '0;
   logic        prev_sclk  = 1'b0;

   int          base_cs;
   int          base_rise;
   logic [31:0] rv;

   assign miso = loop_en ? mosi : miso_val;

   module_pmod_spi_ctrl #(
      .CLK_DIV(4),
      .DATA_W (8)
   ) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .we_i     (we),
      .addr_i   (addr),
      .wr_data_i(wdata),
      .rd_data_o(rd_data),
      .sclk_o   (sclk),
      .mosi_o   (mosi),
      .miso_i   (miso),
      .cs_o     (cs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!cs) cs_low_cnt <= cs_low_cnt + 1;
      if (sclk && !prev_sclk) begin
         rise_cnt  <= rise_cnt + 1;
         mosi_hist <= {mosi_hist[30:0], mosi};
      end
      prev_sclk <= sclk;
   end

   task automatic expect_val(input logic [31:0] v);
      sb.push_back(v);
   endtask

   task automatic check(input string tag, input logic [31:0] obs);
      logic [31:0] exp;
      exp = '0;
      if (sb.size() != 0) exp = sb.pop_front();
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      we    = 1'b1;
      addr  = a;
      wdata = d;
      @(posedge clk);
      #1;
      we    = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      we   = 1'b0;
      addr = a;
      @(posedge clk);
      #1;
      d = rd_data;
   endtask

   task automatic start(input logic [1:0] a, input logic [31:0] tx);
      wr(a, tx);
      base_cs   = cs_low_cnt;
      base_rise = rise_cnt;
      wr(2'b01, 32'h1);
   endtask

   task automatic wait_cs_high(input string tag);
      logic timed_out;
      timed_out = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (cs) begin
            timed_out = 1'b0;
            break;
         end
      end
      @(posedge clk);
      #1;
      expect_val(32'h0);
      check({tag, "_timeout"}, 32'(timed_out));
   endtask

   task automatic finish_check(input string tag, input logic [7:0] tx);
      wait_cs_high(tag);
      expect_val(32'd8);
      check({tag, "_rises"}, 32'(rise_cnt - base_rise));
      expect_val(32'(tx));
      check({tag, "_mosi"}, {24'b0, mosi_hist[7:0]});
      expect_val(32'd72);
      check({tag, "_cs_low"}, 32'(cs_low_cnt - base_cs));
   endtask

   initial begin
      rst      = 1'b1;
      we       = 1'b0;
      addr     = 2'b00;
      wdata    = '0;
      loop_en  = 1'b0;
      miso_val = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      expect_val(32'h1); check("rst_cs", 32'(cs));
      expect_val(32'h0); check("rst_sclk", 32'(sclk));
      expect_val(32'h0); check("rst_mosi", 32'(mosi));
      @(negedge clk);
      rst = 1'b0;
      rd(2'b01, rv); expect_val(32'h0); check("rst_ctrl", rv);
      rd(2'b00, rv); expect_val(32'h0); check("rst_data", rv);

      loop_en = 1'b1;
      start(2'b00, 32'hA5);
      finish_check("loop", 8'hA5);
      rd(2'b01, rv); expect_val(32'h2); check("loop_ctrl", rv);
      rd(2'b00, rv); expect_val(32'hA5); check("loop_rx", rv);

      loop_en  = 1'b0;
      miso_val = 1'b1;
      start(2'b00, 32'h3C);
      finish_check("miso1", 8'h3C);
      rd(2'b00, rv); expect_val(32'hFF); check("miso1_rx", rv);
      rd(2'b01, rv); expect_val(32'h2); check("miso1_ctrl", rv);
      wr(2'b01, 32'h0);
      rd(2'b01, rv); expect_val(32'h0); check("done_clr", rv);

      loop_en = 1'b1;
      start(2'b00, 32'h12);
      repeat (20) @(posedge clk);
      wr(2'b00, 32'h77);
      wr(2'b01, 32'h1);
      rd(2'b01, rv); expect_val(32'h1); check("busy_mid", rv);
      rd(2'b00, rv); expect_val(32'hFF); check("busy_rx_mid", rv);
      repeat (30) @(posedge clk);
      rd(2'b01, rv); expect_val(32'h1); check("busy_late", rv);
      finish_check("busy", 8'h12);
      rd(2'b00, rv); expect_val(32'h12); check("busy_rx", rv);
      rd(2'b01, rv); expect_val(32'h2); check("busy_ctrl", rv);
      base_cs = cs_low_cnt;
      repeat (40) @(posedge clk);
      #1;
      expect_val(32'h0);
      check("busy_single", 32'(cs_low_cnt - base_cs));
      base_cs   = cs_low_cnt;
      base_rise = rise_cnt;
      wr(2'b01, 32'h1);
      finish_check("tx_kept", 8'h12);

      start(2'b10, 32'hC3);
      finish_check("addr2", 8'hC3);
      rd(2'b10, rv); expect_val(32'hC3); check("addr2_rd", rv);
      start(2'b11, 32'h81);
      finish_check("addr3", 8'h81);
      rd(2'b11, rv); expect_val(32'h81); check("addr3_rd", rv);
      start(2'b00, 32'h7E);
      finish_check("addr0", 8'h7E);
      rd(2'b00, rv); expect_val(32'h7E); check("addr0_rd", rv);
      rd(2'b01, rv); expect_val(32'h2); check("addr1_rd", rv);

      start(2'b00, 32'hFF);
      repeat (29) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      expect_val(32'h1); check("mid_rst_cs", 32'(cs));
      expect_val(32'h0); check("mid_rst_sclk", 32'(sclk));
      @(negedge clk);
      rst = 1'b0;
      rd(2'b01, rv); expect_val(32'h0); check("mid_rst_ctrl", rv);
      rd(2'b00, rv); expect_val(32'h0); check("mid_rst_rx", rv);
      start(2'b00, 32'h96);
      finish_check("after_rst", 8'h96);
      rd(2'b00, rv); expect_val(32'h96); check("after_rst_rx", rv);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
